slt_iter: RTL and testbench

- Parametrised, multi-cycle set-less-than unit for the MiniMIPS ALU path. It generalises the 32-bit combinational signed SLT.
- Adds: configurable operand width, an unsigned (SLTU) mode, an equality flag, and an iterative MSB-first chunk comparator with early termination.
- Uses a start/busy/done handshake so the control unit can stall while a compare completes.

---
 rtl/slt_iter.sv | 111 +++++++++++
 tb/tb_slt_iter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/slt_iter.sv
// Multi-cycle set-less-than for the MiniMIPS ALU: signed/unsigned compare of two
// WIDTH-bit operands, scanned MSB-first CHUNK bits per cycle with early exit.
module slt_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_unsigned,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             lt,
  output logic             eq
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic             done_q, done_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic [CHUNK-1:0] chunk_a, chunk_b;

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both SLT and SLTU with no overflow case.
  function automatic logic [WIDTH-1:0] bias(input logic [WIDTH-1:0] v,
                                            input logic             uns);
    return uns ? v : (v ^ MSB_MASK);
  endfunction

  // Operands shift left each step, so the current chunk is always at the top.
  assign chunk_a = a_q[WIDTH-1 -: CHUNK];
  assign chunk_b = b_q[WIDTH-1 -: CHUNK];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    done_d  = 1'b0;
    lt_d    = lt_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = bias(a, is_unsigned);
          b_d     = bias(b, is_unsigned);
          k_d     = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (chunk_a != chunk_b) begin
          lt_d    = (chunk_a < chunk_b);
          eq_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (k_q == K_LAST) begin
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          k_d = k_q + KW'(1);
          a_d = a_q << CHUNK;
          b_d = b_q << CHUNK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy   = (state_q == SCAN);
  assign done   = done_q;
  assign lt     = lt_q;
  assign eq     = eq_q;
  assign result = {{(WIDTH-1){1'b0}}, lt_q};

endmodule

// File: tb/tb_slt_iter.sv
// Scoreboard bench for slt_iter: 32-bit/4-bit-chunk and 8-bit/single-chunk instances.
module tb_slt_iter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic        start32 = 1'b0, u32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic        busy32, done32, lt32, eq32;

  logic        start8 = 1'b0, u8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, res8;
  logic        busy8, done8, lt8, eq8;

  typedef struct {int t; logic lt; logic eq;} exp_t;
  exp_t q32[$];
  exp_t q8[$];
  logic h32_lt = 1'b0, h32_eq = 1'b0, h8_lt = 1'b0, h8_eq = 1'b0;

  slt_iter #(.WIDTH(32), .CHUNK(4)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32),
    .is_unsigned(u32), .busy(busy32), .done(done32), .result(res32),
    .lt(lt32), .eq(eq32));

  slt_iter #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .is_unsigned(u8), .busy(busy8), .done(done8), .result(res8),
    .lt(lt8), .eq(eq8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor for the 32-bit instance: pop on done, otherwise outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      h32_lt = 1'b0;
      h32_eq = 1'b0;
    end else if (done32) begin
      if (q32.size() == 0) begin
        chk("d32_spurious_done", 32'(done32), 32'd0);
      end else begin
        e = q32.pop_front();
        chk("d32_done_cycle", 32'(cyc), 32'(e.t));
        chk("d32_lt", 32'(lt32), 32'(e.lt));
        chk("d32_eq", 32'(eq32), 32'(e.eq));
        chk("d32_result", res32, {31'b0, e.lt});
        h32_lt = e.lt;
        h32_eq = e.eq;
      end
    end else begin
      chk("d32_hold_lt", 32'(lt32), 32'(h32_lt));
      chk("d32_hold_eq", 32'(eq32), 32'(h32_eq));
      chk("d32_hold_result", res32, {31'b0, h32_lt});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      h8_lt = 1'b0;
      h8_eq = 1'b0;
    end else if (done8) begin
      if (q8.size() == 0) begin
        chk("d8_spurious_done", 32'(done8), 32'd0);
      end else begin
        e = q8.pop_front();
        chk("d8_done_cycle", 32'(cyc), 32'(e.t));
        chk("d8_lt", 32'(lt8), 32'(e.lt));
        chk("d8_eq", 32'(eq8), 32'(e.eq));
        chk("d8_result", 32'(res8), {31'b0, e.lt});
        h8_lt = e.lt;
        h8_eq = e.eq;
      end
    end else begin
      chk("d8_hold_lt", 32'(lt8), 32'(h8_lt));
      chk("d8_hold_eq", 32'(eq8), 32'(h8_eq));
      chk("d8_hold_result", 32'(res8), {31'b0, h8_lt});
    end
  end

  // Called at a negedge; j is the index of the first differing chunk.
  task automatic issue32(input logic [31:0] av, input logic [31:0] bv, input logic uns,
                         input logic elt, input logic eeq, input int j);
    start32 = 1'b1; a32 = av; b32 = bv; u32 = uns;
    q32.push_back('{cyc + 2 + j, elt, eeq});
    @(negedge clk);
    start32 = 1'b0;
    a32 = ~av; b32 = ~bv; u32 = ~uns;
    chk("d32_busy_after_start", 32'(busy32), 32'd1);
  endtask

  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic uns,
                        input logic elt, input logic eeq);
    start8 = 1'b1; a8 = av; b8 = bv; u8 = uns;
    q8.push_back('{cyc + 2, elt, eeq});
    @(negedge clk);
    start8 = 1'b0;
    chk("d8_busy_after_start", 32'(busy8), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (q32.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    chk("pending_after_timeout", 32'(q32.size() + q8.size()), 32'd0);
    @(negedge clk);
    chk("d32_idle_busy", 32'(busy32), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy32), 32'd0);
    chk("rst_done", 32'(done32), 32'd0);
    chk("rst_result", res32, 32'd0);
    chk("rst_lt", 32'(lt32), 32'd0);
    chk("rst_eq", 32'(eq32), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue32(32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 7);                wait_idle();
    issue32(32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, 0);         wait_idle();
    issue32(32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, 1'b0, 0);         wait_idle();
    issue32(32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1, 7);  wait_idle();
    issue32(32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b1, 7);  wait_idle();
    issue32(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 0);  wait_idle();
    issue32(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 0);  wait_idle();
    issue32(32'h0000A000, 32'h0000A100, 1'b1, 1'b1, 1'b0, 5);  wait_idle();

    // Start while busy is ignored; then restart in the done cycle.
    issue32(32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 7);
    @(negedge clk);
    start32 = 1'b1; a32 = 32'd7; b32 = 32'd5; u32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int i = 0; i < 20 && !done32; i++) @(negedge clk);
    chk("b2b_done_seen", 32'(done32), 32'd1);
    issue32(32'd9, 32'd2, 1'b0, 1'b0, 1'b0, 7);
    wait_idle();

    // Reset mid-scan aborts with all outputs cleared immediately.
    issue32(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 0);  wait_idle();
    issue32(32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    q32.delete();
    #1;
    chk("abort_busy", 32'(busy32), 32'd0);
    chk("abort_done", 32'(done32), 32'd0);
    chk("abort_result", res32, 32'd0);
    chk("abort_lt", 32'(lt32), 32'd0);
    chk("abort_eq", 32'(eq32), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (12) @(negedge clk);
    issue32(32'd3, 32'd3, 1'b0, 1'b0, 1'b1, 7);                wait_idle();

    // Single-chunk instance.
    issue8(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);                    wait_idle();
    issue8(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);                    wait_idle();
    issue8(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1);                    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
